// File: rtl/smac_acc_ctrl.sv
// Sequencing controller for a MAC accumulator: clears, gathers PA beats per group, hands out NG group results.
// Optional stall counter enabled by defining SMAC_ACC_CTRL_STALL_CNT_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   CLR   | one-cycle accumulator clear, beat counter reset
//   ACC   | accepting operand beats until PA have been taken
//   WOUT  | presenting group result until consumer takes it
//   FIN   | one-cycle job-complete pulse
module smac_acc_ctrl #(
   parameter int PA = 8,
   parameter int NG = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  ac1_en,
   output logic                  acc_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [$clog2(NG):0]   grp_idx,
   output logic                  busy,
   output logic                  done
`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int BW = $clog2(PA) + 1;
   localparam int GW = $clog2(NG) + 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(PA - 1);
   localparam logic [GW-1:0] GRP_LAST  = GW'(NG - 1);

   typedef enum logic [2:0] {IDLE, CLR, ACC, WOUT, FIN} state_t;

   state_t         state, state_nxt;
   logic [BW-1:0]  beat_cnt, beat_nxt;
   logic [GW-1:0]  grp_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
         grp_idx  <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_nxt;
         grp_idx  <= grp_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_cnt;
      grp_nxt   = grp_idx;
      in_ready  = 1'b0;
      acc_clr   = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CLR;
               grp_nxt   = '0;
            end
         end
         CLR: begin
            acc_clr   = 1'b1;
            beat_nxt  = '0;
            state_nxt = ACC;
         end
         ACC: begin
            in_ready = 1'b1;
            // the final beat leaves the counter at PA-1 so it never exceeds it
            if (in_valid) begin
               if (beat_cnt == BEAT_LAST) state_nxt = WOUT;
               else                       beat_nxt  = beat_cnt + BW'(1);
            end
         end
         WOUT: begin
            out_valid = 1'b1;
            out_last  = (grp_idx == GRP_LAST);
            if (out_ready) begin
               if (grp_idx == GRP_LAST) begin
                  state_nxt = FIN;
               end else begin
                  grp_nxt   = grp_idx + GW'(1);
                  state_nxt = CLR;
               end
            end
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ac1_en = in_valid & in_ready;

`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (state == IDLE && start) begin
         stall_cnt <= '0;
      end else if (((state == ACC && !in_valid) || (state == WOUT && !out_ready))
                   && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_smac_acc_ctrl.sv
// Directed bench for smac_acc_ctrl: PA=4/NG=2 instance for the main scenarios, PA=1/NG=1 for the degenerate case.
module tb_smac_acc_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start, in_valid, out_ready;
   logic       in_ready, ac1_en, acc_clr, out_valid, out_last, busy, done;
   logic [1:0] grp_idx;
`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] stall_cnt1;
`endif

   logic start1, in_valid1, out_ready1;
   logic in_ready1, ac1_en1, acc_clr1, out_valid1, out_last1, busy1, done1;
   logic [0:0] grp_idx1;

   smac_acc_ctrl #(.PA(4), .NG(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .ac1_en(ac1_en), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .grp_idx(grp_idx), .busy(busy), .done(done)
`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   smac_acc_ctrl #(.PA(1), .NG(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
      .ac1_en(ac1_en1), .acc_clr(acc_clr1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_last(out_last1), .grp_idx(grp_idx1), .busy(busy1), .done(done1)
`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
      , .stall_cnt(stall_cnt1)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   int   clr_c[$];
   int   ov_rise[$];
   int   last_c[$];
   int   done_c[$];
   int   ac1_g[2];
   logic busy_h[64];
   int   stall_h[64];
   logic prev_ov;

   // one job on u_dut; cycle 0 carries the start pulse, bp stalls the first WOUT from cycle 6,
   // xs re-pulses start in cycles 3 (ACC) and 13 (FIN)
   task automatic run(input int ncyc, input bit gaps, input int bp, input bit xs);
      clr_c.delete(); ov_rise.delete(); last_c.delete(); done_c.delete();
      ac1_g[0] = 0; ac1_g[1] = 0;
      prev_ov  = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         start     = (c == 0) || (xs && (c == 3 || c == 13));
         in_valid  = gaps ? (c % 2 == 1) : 1'b1;
         out_ready = !(c >= 6 && c < 6 + bp);
         @(negedge clk);
         if (acc_clr) clr_c.push_back(c);
         if (ac1_en) ac1_g[grp_idx[0]]++;
         if (out_valid && !prev_ov) ov_rise.push_back(c);
         prev_ov = out_valid;
         if (out_last) last_c.push_back(c);
         if (done) done_c.push_back(c);
         busy_h[c] = busy;
`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
         stall_h[c] = int'(stall_cnt);
`else
         stall_h[c] = 0;
`endif
         if (bp > 0 && c >= 6 && c <= 6 + bp) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_grp_idx",   grp_idx,   0);
            check("bp_out_last",  out_last,  0);
            check("bp_acc_clr",   acc_clr,   0);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic check_all_low(input string tag);
      check({tag, "_in_ready"},  in_ready,  0);
      check({tag, "_ac1_en"},    ac1_en,    0);
      check({tag, "_acc_clr"},   acc_clr,   0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_last"},  out_last,  0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_done"},      done,      0);
      check({tag, "_grp_idx"},   grp_idx,   0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      start1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;

      // reset holds every output low even with requests pending
      repeat (2) @(negedge clk);
      check_all_low("rst");
      check("rst_busy1", busy1, 0);
      check("rst_acc_clr1", acc_clr1, 0);
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      @(posedge clk); #1;

      // nominal
      run(16, 1'b0, 0, 1'b0);
      check("nom_clr_n",  clr_c.size(), 2);
      check("nom_clr0",   clr_c[0], 1);
      check("nom_clr1",   clr_c[1], 7);
      check("nom_ac1_g0", ac1_g[0], 4);
      check("nom_ac1_g1", ac1_g[1], 4);
      check("nom_last_n", last_c.size(), 1);
      check("nom_last_c", last_c[0], 12);
      check("nom_done_n", done_c.size(), 1);
      check("nom_done_c", done_c[0], 13);
      check("nom_busy0",  busy_h[0], 0);
      check("nom_busy1",  busy_h[1], 1);
      check("nom_busy13", busy_h[13], 1);
      check("nom_busy14", busy_h[14], 0);

      // input gaps
      run(24, 1'b1, 0, 1'b0);
      check("gap_ac1_g0", ac1_g[0], 4);
      check("gap_ac1_g1", ac1_g[1], 4);
      check("gap_wout_n", ov_rise.size(), 2);
      check("gap_wout0",  ov_rise[0], 10);
      check("gap_wout1",  ov_rise[1], 20);
      check("gap_done",   done_c[0], 21);
`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
      check("gap_stall0", stall_h[10], 4);
      check("gap_stall1", stall_h[20], 8);
`endif

      // backpressure
      run(22, 1'b0, 5, 1'b0);
      check("bp_clr_n",   clr_c.size(), 2);
      check("bp_clr1",    clr_c[1], 12);
      check("bp_ac1_g0",  ac1_g[0], 4);
      check("bp_ac1_g1",  ac1_g[1], 4);
      check("bp_last_c",  last_c[0], 17);
      check("bp_done",    done_c[0], 18);
`ifdef SMAC_ACC_CTRL_STALL_CNT_EN
      check("bp_stall",   stall_h[12], 5);
`endif

      // start pulses while busy are ignored
      run(18, 1'b0, 0, 1'b1);
      check("xs_clr_n",   clr_c.size(), 2);
      check("xs_clr1",    clr_c[1], 7);
      check("xs_ac1_g0",  ac1_g[0], 4);
      check("xs_done_n",  done_c.size(), 1);
      check("xs_done",    done_c[0], 13);
      check("xs_busy14",  busy_h[14], 0);
      check("xs_busy15",  busy_h[15], 0);

      // reset during ACC after two beats
      for (int c = 0; c < 4; c++) begin
         start = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("mid_in_acc", in_ready, 1);
      rst = 1'b1;
      #1;
      check_all_low("mid_rst");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("mid_rst_done", done, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run(16, 1'b0, 0, 1'b0);
      check("mid_clr_n",  clr_c.size(), 2);
      check("mid_clr0",   clr_c[0], 1);
      check("mid_ac1_g0", ac1_g[0], 4);
      check("mid_ac1_g1", ac1_g[1], 4);
      check("mid_done",   done_c[0], 13);

      // degenerate PA=1, NG=1
      for (int c = 0; c < 7; c++) begin
         start1 = (c == 0);
         @(negedge clk);
         check("deg_acc_clr",   acc_clr1,   32'(c == 1));
         check("deg_in_ready",  in_ready1,  32'(c == 2));
         check("deg_ac1_en",    ac1_en1,    32'(c == 2));
         check("deg_out_valid", out_valid1, 32'(c == 3));
         check("deg_out_last",  out_last1,  32'(c == 3));
         check("deg_done",      done1,      32'(c == 4));
         check("deg_busy",      busy1,      32'(c >= 1 && c <= 4));
         check("deg_grp_idx",   grp_idx1,   0);
         @(posedge clk); #1;
      end
      start1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
